// File: rtl/ctc_int_ctrl.sv
// Z80 CTC interrupt controller: captures per-channel zero-count events, arbitrates
// them by fixed priority, runs the mode-2 acknowledge and daisy chain, and snoops RETI.
module ctc_int_ctrl #(
  parameter int DWID = 8,
  parameter int NCH  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NCH-1:0]  zc_to,
  input  logic [NCH-1:0]  int_en,
  input  logic            vec_we,
  input  logic            m1_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic [DWID-1:0] din,
  output logic [DWID-1:0] dout,
  output logic            oe_n,
  input  logic            iei,
  output logic            ieo,
  output logic            int_n
);

  localparam int VBW = DWID - 3;

  typedef enum logic {
    SN_IDLE,
    SN_GOT_ED
  } snoop_e;

  function automatic logic [NCH-1:0] lowest_onehot(input logic [NCH-1:0] v);
    logic [NCH-1:0] oh;
    logic           found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i] && !found) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [NCH-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  logic [NCH-1:0]  zc_prev_q, zc_prev_d;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  in_service_q, in_service_d;
  logic [VBW-1:0]  vec_base_q, vec_base_d;
  logic            int_n_q, int_n_d;
  logic            oe_n_q, oe_n_d;
  logic [DWID-1:0] dout_q, dout_d;
  logic            ack_prev_q, ack_prev_d;
  logic            fetch_prev_q, fetch_prev_d;
  snoop_e          snoop_q, snoop_d;

  logic            ack, ack_start, ack_take;
  logic            fetch, fetch_start;
  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  ack_oh, reti_clr;
  logic [1:0]      ack_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    zc_prev_d    = zc_to;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    vec_base_d   = vec_base_q;
    int_n_d      = int_n_q;
    oe_n_d       = oe_n_q;
    dout_d       = dout_q;
    snoop_d      = snoop_q;
    reti_clr     = '0;

    ack         = ~m1_n & ~iorq_n;
    ack_start   = ack & ~ack_prev_q;
    ack_prev_d  = ack;
    fetch       = ~m1_n & ~rd_n & iorq_n;
    fetch_start = fetch & ~fetch_prev_q;
    fetch_prev_d = fetch;

    rise     = zc_to & ~zc_prev_q;
    ack_oh   = lowest_onehot(pending_q);
    ack_idx  = lowest_idx(pending_q);
    ack_take = ack_start & ~int_n_q & (|pending_q) & ~(|in_service_q);

    if (vec_we) vec_base_d = din[DWID-1:3];

    // RETI is ED 4D on consecutive opcode fetches; other bus cycles leave the state alone.
    if (fetch_start) begin
      unique case (snoop_q)
        SN_IDLE: begin
          snoop_d = (din == DWID'(8'hED)) ? SN_GOT_ED : SN_IDLE;
        end
        SN_GOT_ED: begin
          if (din == DWID'(8'h4D)) begin
            snoop_d = SN_IDLE;
            if (iei) reti_clr = lowest_onehot(in_service_q);
          end else if (din == DWID'(8'hED)) begin
            snoop_d = SN_GOT_ED;
          end else begin
            snoop_d = SN_IDLE;
          end
        end
        default: snoop_d = SN_IDLE;
      endcase
    end

    // A fresh rise wins over the acknowledge clear; disabling a channel drops its request.
    pending_d    = ((pending_q & ~(ack_take ? ack_oh : '0)) | (rise & int_en)) & int_en;
    in_service_d = (in_service_q & ~reti_clr) | (ack_take ? ack_oh : '0);

    int_n_d = ~(iei & (|pending_q) & ~(|in_service_q));

    if (ack_take) begin
      dout_d = {vec_base_q, ack_idx, 1'b0};
      oe_n_d = 1'b0;
    end else if (!ack) begin
      dout_d = '0;
      oe_n_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      zc_prev_q    <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      vec_base_q   <= '0;
      int_n_q      <= 1'b1;
      oe_n_q       <= 1'b1;
      dout_q       <= '0;
      ack_prev_q   <= 1'b0;
      fetch_prev_q <= 1'b0;
      snoop_q      <= SN_IDLE;
    end else begin
      zc_prev_q    <= zc_prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      vec_base_q   <= vec_base_d;
      int_n_q      <= int_n_d;
      oe_n_q       <= oe_n_d;
      dout_q       <= dout_d;
      ack_prev_q   <= ack_prev_d;
      fetch_prev_q <= fetch_prev_d;
      snoop_q      <= snoop_d;
    end
  end

  assign dout  = dout_q;
  assign oe_n  = oe_n_q;
  assign int_n = int_n_q;
  assign ieo   = iei & ~(|in_service_q) & ~(|pending_q);

endmodule

// File: doc/ctc_int_ctrl.md
Name: ctc_int_ctrl

Overview:
- Interrupt controller for the four-channel Z80 CTC. It sits directly downstream of the per-channel counter/timer cores.
- Consumes each channel's zero-count pulse and interrupt-enable bit, and arbitrates fixed priority (channel 0 highest).
- Drives the Z80 mode-2 interrupt request, the IEI/IEO daisy chain, and the acknowledge vector.
- Snoops opcode fetches for RETI (ED 4D) to release the in-service channel.

Parameters:
- DWID, 8, data bus width.
- NCH, 4, number of channels; 1..4 (channel index occupies vector bits 2:1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- zc_to  in  NCH  per-channel zero-count/timeout from the counter cores; level, may stay high several cycles
- int_en  in  NCH  per-channel interrupt enable (CCW bit 7)
- vec_we  in  1  one-cycle strobe: latch interrupt vector base from din
- m1_n  in  1  Z80 M1, active-low
- iorq_n  in  1  Z80 IORQ, active-low
- rd_n  in  1  Z80 RD, active-low
- din  in  DWID  CPU data bus (vector write, opcode snoop)
- dout  out  DWID  vector driven during acknowledge
- oe_n  out  1  dout valid/output enable, active-low
- iei  in  1  daisy-chain enable in, active-high
- ieo  out  1  daisy-chain enable out
- int_n  out  1  interrupt request to CPU, active-low

Behaviour:
- Interface: one clock (clk); reset_n is synchronous and active-low. All state is updated only on the rising edge of clk.
- Reset values:
  - pending=0, in_service=0, vec_base=0, snoop state=IDLE.
  - int_n=1, oe_n=1, dout=0, ieo follows its equation.
  - Reset mid-acknowledge or mid-service drops everything; the next cycle is idle.
- Vector register:
  - On vec_we, vec_base <= din[7:3].
  - Vector word = {vec_base, idx[1:0], 1'b0}, where idx is the channel number.
- Event capture:
  - zc_prev <= zc_to; rise[i] = zc_to[i] & !zc_prev[i].
  - If rise[i] and int_en[i], set pending[i] next cycle.
  - When int_en[i]=0, pending[i] is cleared. An already-set in_service bit is not affected by int_en.
- Request:
  - int_n registered: int_n <= !(iei & |pending & ~|in_service), i.e. it asserts one cycle after pending becomes visible.
  - int_n deasserts one cycle after iei falls or the acknowledge sets in_service.
- Daisy chain (combinational from registered state):
  - ieo = iei & ~|in_service & ~|pending.
  - A pending request blocks lower-priority devices before acknowledge.
- Acknowledge:
  - ack = !m1_n & !iorq_n; ack_start = ack & !ack_prev.
  - On ack_start with int_n=0: idx = lowest-numbered set pending bit; clear pending[idx]; set in_service[idx]; dout <= vector; oe_n <= 0.
  - dout/oe_n are held while ack stays true. When ack is released: oe_n <= 1, dout <= 0.
  - ack_start with int_n=1 is ignored (oe_n stays 1).
- Simultaneous events: a rise[i] in the same cycle pending[i] is cleared by acknowledge sets pending[i] (set wins). It is serviced after the current RETI.
- RETI snoop FSM (states IDLE, GOT_ED):
  - Opcode fetch = !m1_n & !rd_n & iorq_n. The opcode is sampled from din on the first clk of each fetch (edge-detected).
  - IDLE: opcode 8'hED -> GOT_ED; any other opcode -> IDLE.
  - GOT_ED: opcode 8'h4D -> if iei=1 and |in_service, clear the lowest-numbered in_service bit; then -> IDLE.
  - GOT_ED: opcode 8'hED -> GOT_ED; any other opcode -> IDLE.
  - Non-fetch cycles do not change state.
  - RETI seen with iei=0 belongs to a higher-priority device: ignored, state -> IDLE.
- Only one in_service bit can be set at a time, because acknowledge requires ~|in_service via int_n.

Test Plan:
- Single channel:
  - Stimulus: vec_we din=8'hA8; int_en=4'b0100; pulse zc_to[2] high 5 cycles.
  - Response: pending=0100 after 1 clk and int_n=0 one clk later.
  - Stimulus: assert m1_n=0/iorq_n=0.
  - Response: dout=8'hAC, oe_n=0 next clk; int_n=1; ieo=0.
- Priority:
  - Stimulus: zc_to rises on ch3 and ch1 in the same cycle; all enabled.
  - Response: first acknowledge returns vector bits 2:1=01.
  - Stimulus: RETI (fetch ED then 4D).
  - Response: in_service clears; int_n reasserts; second acknowledge returns bits 2:1=11.
- Daisy chain:
  - Stimulus: iei=0 with pending=0001.
  - Response: int_n=1, ieo=0; acknowledge is ignored (oe_n=1).
  - Stimulus: raise iei.
  - Response: int_n=0 within 1 clk.
- RETI filtering:
  - Stimulus: fetch ED,00,4D.
  - Response: in_service unchanged.
  - Stimulus: fetch ED,ED,4D.
  - Response: in_service cleared.
  - Stimulus: ED,4D with iei=0.
  - Response: ignored.
- Enable/disable:
  - Stimulus: int_en[0]=0 during a zc_to[0] rise.
  - Response: no pending, int_n=1.
  - Stimulus: pending set, then int_en drops.
  - Response: pending clears and int_n returns to 1.
- Reset:
  - Stimulus: assert reset_n=0 for 1 clk while oe_n=0 and in_service=0010.
  - Response: next clk oe_n=1, dout=0, int_n=1, in_service=0, vec_base=0.
